// File: rtl/param_mux_scanner.sv
// Registered N-channel, W-bit multiplexer with manual select and an auto-scan
// sequencer that dwells a fixed number of cycles on each channel.
module param_mux_scanner #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        mode,
  input  logic [$clog2(CHANNELS)-1:0] s,
  input  logic [CHANNELS*WIDTH-1:0]   d,
  output logic [WIDTH-1:0]            y,
  output logic [$clog2(CHANNELS)-1:0] ch,
  output logic                        valid,
  output logic                        wrap
);

  localparam int unsigned SELW = $clog2(CHANNELS);
  localparam int unsigned CNTW = $clog2(DWELL + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [SELW-1:0]   ptr, ptr_nxt;
  logic [CNTW-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0]  y_nxt;
  logic [SELW-1:0]   ch_nxt;
  logic              valid_nxt;
  logic              wrap_nxt;
  logic [WIDTH-1:0]  chans [CHANNELS];
  logic [SELW-1:0]   scan_ptr;
  logic [CNTW-1:0]   scan_cnt;
  logic              s_in_range;

  // Unflatten the channel bus so channels can be indexed directly.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      chans[k] = d[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      y     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      y     <= y_nxt;
      ch    <= ch_nxt;
      valid <= valid_nxt;
      wrap  <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        IDLE:    state_nxt = mode ? SCAN : MAN;
        MAN:     state_nxt = mode ? SCAN : MAN;
        SCAN:    state_nxt = mode ? SCAN : MAN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A scan entered from IDLE or MAN always starts fresh at channel 0.
  assign scan_ptr   = (state == SCAN) ? ptr : '0;
  assign scan_cnt   = (state == SCAN) ? cnt : '0;
  assign s_in_range = ({1'b0, s} < (SELW+1)'(CHANNELS));

  always_comb begin
    y_nxt     = y;
    ch_nxt    = ch;
    valid_nxt = valid;
    wrap_nxt  = 1'b0;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    if (en) begin
      if (mode) begin
        y_nxt     = chans[scan_ptr];
        ch_nxt    = scan_ptr;
        valid_nxt = 1'b1;
        wrap_nxt  = (state == SCAN) && (scan_ptr == '0) && (ch == SELW'(CHANNELS - 1));
        if (scan_cnt == CNTW'(DWELL - 1)) begin
          cnt_nxt = '0;
          ptr_nxt = (scan_ptr == SELW'(CHANNELS - 1)) ? '0 : scan_ptr + SELW'(1);
        end else begin
          cnt_nxt = scan_cnt + CNTW'(1);
          ptr_nxt = scan_ptr;
        end
      end else begin
        y_nxt     = s_in_range ? chans[s] : '0;
        ch_nxt    = s;
        valid_nxt = s_in_range;
        ptr_nxt   = '0;
        cnt_nxt   = '0;
      end
    end
  end

endmodule

// File: tb/tb_param_mux_scanner.sv
// Directed bench for param_mux_scanner: default 4x8 scanner driven from a
// vector table, plus a 3-channel, 4-bit, single-cycle-dwell instance.
module tb_param_mux_scanner;

  typedef struct {
    logic        rst;
    logic        en;
    logic        mode;
    logic [1:0]  s;
    logic [31:0] d;
    logic [7:0]  y;
    logic [1:0]  ch;
    logic        valid;
    logic        wrap;
  } vec_t;

  localparam logic [31:0] D0   = 32'h03020100;
  localparam logic [31:0] DALT = 32'h03AA0100;

  logic        clk = 1'b0;
  logic        rst, en, mode;
  logic [1:0]  s;
  logic [31:0] d;
  logic [7:0]  y;
  logic [1:0]  ch;
  logic        valid, wrap;

  logic        rst3, en3, mode3;
  logic [1:0]  s3;
  logic [11:0] d3;
  logic [3:0]  y3;
  logic [1:0]  ch3;
  logic        valid3, wrap3;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  param_mux_scanner dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .d(d),
    .y(y), .ch(ch), .valid(valid), .wrap(wrap)
  );

  param_mux_scanner #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) dut3 (
    .clk(clk), .rst(rst3), .en(en3), .mode(mode3), .s(s3), .d(d3),
    .y(y3), .ch(ch3), .valid(valid3), .wrap(wrap3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic m, input logic [1:0] sel,
                     input logic [31:0] dd, input logic [7:0] ey, input logic [1:0] ech,
                     input logic ev, input logic ew);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.s = sel; v.d = dd;
    v.y = ey; v.ch = ech; v.valid = ev; v.wrap = ew;
    vecs.push_back(v);
  endtask

  // Scan edge k (1-based) of a fresh DWELL=4 scan over D0.
  task automatic add_scan(input int k, input logic [31:0] dd);
    logic [1:0] c;
    c = 2'(((k - 1) / 4) % 4);
    add(1'b0, 1'b1, 1'b1, 2'd0, dd, 8'(c), c, 1'b1, 1'(k % 16 == 1 && k > 1));
  endtask

  task automatic step3(input string name, input logic r, input logic e, input logic m,
                       input logic [1:0] sel, input logic [3:0] ey, input logic [1:0] ech,
                       input logic ev, input logic ew);
    @(negedge clk);
    rst3 = r; en3 = e; mode3 = m; s3 = sel;
    @(posedge clk);
    #1;
    chk({name, ".y"}, 32'(y3), 32'(ey));
    chk({name, ".ch"}, 32'(ch3), 32'(ech));
    chk({name, ".valid"}, 32'(valid3), 32'(ev));
    chk({name, ".wrap"}, 32'(wrap3), 32'(ew));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; s = '0; d = D0;
    rst3 = 1'b1; en3 = 1'b0; mode3 = 1'b0; s3 = '0; d3 = 12'h5A3;

    // Reset held with scan requested and nonzero data
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b1, 2'd0, D0, 8'd0, 2'd0, 1'b0, 1'b0);
    // Scan from IDLE through one full rollover
    for (int k = 1; k <= 18; k++) add_scan(k, D0);
    // Re-run to the wrap edge, then freeze on it: pulse must not stretch
    add(1'b1, 1'b1, 1'b1, 2'd0, D0, 8'd0, 2'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 17; k++) add_scan(k, D0);
    add(1'b0, 1'b0, 1'b1, 2'd0, D0, 8'd0, 2'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 2'd0, D0, 8'd0, 2'd0, 1'b1, 1'b0);
    // Manual sweep
    add(1'b1, 1'b1, 1'b0, 2'd0, D0, 8'd0, 2'd0, 1'b0, 1'b0);
    for (int sel = 0; sel < 4; sel++)
      for (int r = 0; r < 2; r++)
        add(1'b0, 1'b1, 1'b0, 2'(sel), D0, 8'(sel), 2'(sel), 1'b1, 1'b0);
    // Freeze mid-dwell, resume, and live data change while held
    add(1'b1, 1'b1, 1'b1, 2'd0, D0, 8'd0, 2'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) add_scan(k, D0);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b1, 2'd0, D0, 8'd1, 2'd1, 1'b1, 1'b0);
    add_scan(7, D0);
    add_scan(8, D0);
    add_scan(9, D0);
    add(1'b0, 1'b1, 1'b1, 2'd0, DALT, 8'hAA, 2'd2, 1'b1, 1'b0);
    add_scan(11, D0);
    // Mode switch mid-scan, re-entry, then reset mid-scan
    add(1'b1, 1'b1, 1'b1, 2'd0, D0, 8'd0, 2'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) add_scan(k, D0);
    add(1'b0, 1'b1, 1'b0, 2'd3, D0, 8'd3, 2'd3, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 2'd0, D0, 8'd0, 2'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 2'd0, D0, 8'd0, 2'd0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 2'd0, D0, 8'd0, 2'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) add_scan(k, D0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
      s = vecs[i].s; d = vecs[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.y", i), 32'(y), 32'(vecs[i].y));
      chk($sformatf("vec%0d.ch", i), 32'(ch), 32'(vecs[i].ch));
      chk($sformatf("vec%0d.valid", i), 32'(valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d.wrap", i), 32'(wrap), 32'(vecs[i].wrap));
    end

    // 3-channel instance: out-of-range select, then DWELL=1 scan with wraps
    step3("c3_rst",   1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 2'd0, 1'b0, 1'b0);
    step3("c3_oor",   1'b0, 1'b1, 1'b0, 2'd3, 4'h0, 2'd3, 1'b0, 1'b0);
    step3("c3_sel2",  1'b0, 1'b1, 1'b0, 2'd2, 4'h5, 2'd2, 1'b1, 1'b0);
    step3("c3_scan0", 1'b0, 1'b1, 1'b1, 2'd0, 4'h3, 2'd0, 1'b1, 1'b0);
    step3("c3_scan1", 1'b0, 1'b1, 1'b1, 2'd0, 4'hA, 2'd1, 1'b1, 1'b0);
    step3("c3_scan2", 1'b0, 1'b1, 1'b1, 2'd0, 4'h5, 2'd2, 1'b1, 1'b0);
    step3("c3_wrap1", 1'b0, 1'b1, 1'b1, 2'd0, 4'h3, 2'd0, 1'b1, 1'b1);
    step3("c3_scan4", 1'b0, 1'b1, 1'b1, 2'd0, 4'hA, 2'd1, 1'b1, 1'b0);
    step3("c3_hold",  1'b0, 1'b0, 1'b1, 2'd0, 4'hA, 2'd1, 1'b1, 1'b0);
    step3("c3_scan5", 1'b0, 1'b1, 1'b1, 2'd0, 4'h5, 2'd2, 1'b1, 1'b0);
    step3("c3_wrap2", 1'b0, 1'b1, 1'b1, 2'd0, 4'h3, 2'd0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
